// File: rtl/la_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : la_seq_pkg
// Description : Shared opcodes, state encoding, grant encoding and
//               la_data_out field positions for the checkbit sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package la_seq_pkg;

    // Command opcodes carried in {op[1:0], data[15:0]}
    localparam logic [1:0] OP_NOP  = 2'd0;
    localparam logic [1:0] OP_WCHK = 2'd1;
    localparam logic [1:0] OP_LOAD = 2'd2;
    localparam logic [1:0] OP_RUN  = 2'd3;

    // Sequencer states; the encoding is visible on the status outputs
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Grant encoding as reported in last_grant
    localparam logic GNT_LA = 1'b1;
    localparam logic GNT_WB = 1'b0;

    // la_data_out field positions
    localparam int LDO_CHK_LSB   = 0;
    localparam int LDO_CNT_LSB   = 16;
    localparam int LDO_BUSY      = 32;
    localparam int LDO_STATE_LSB = 33;
    localparam int LDO_LAST_GNT  = 35;
    localparam int LDO_OVERRUN   = 36;

    typedef struct packed {
        logic [1:0]  op;
        logic [15:0] data;
    } cmd_t;

endpackage
`default_nettype wire

// File: rtl/la_seq_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : la_seq_rr_arb
// Description : Two-requester (LA / Wishbone) round-robin arbiter. Grants are
//               combinational while enabled; the last winner is remembered.
// Revision    : 1.0 - initial release
// ============================================================================
module la_seq_rr_arb
    import la_seq_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_req_la,
    input  logic i_req_wb,
    output logic o_gnt_la,
    output logic o_gnt_wb,
    output logic o_last_grant
);

    logic r_last;

    // Pick a winner; on contention the requester that did not win last time goes
    always_comb begin
        o_gnt_la = 1'b0;
        o_gnt_wb = 1'b0;
        if (i_en) begin
            if (i_req_la && i_req_wb) begin
                if (r_last == GNT_WB) begin
                    o_gnt_la = 1'b1;
                end else begin
                    o_gnt_wb = 1'b1;
                end
            end else begin
                o_gnt_la = i_req_la;
                o_gnt_wb = i_req_wb;
            end
        end
    end

    // Remember the most recent winner; WB counts as last after reset so LA wins first
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_last <= GNT_WB;
        end else if (o_gnt_la) begin
            r_last <= GNT_LA;
        end else if (o_gnt_wb) begin
            r_last <= GNT_WB;
        end
    end

    assign o_last_grant = r_last;

endmodule
`default_nettype wire

// File: rtl/la_checkbit_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : la_checkbit_sequencer
// Description : Owns the 16-bit checkbit field on mprj_io[31:16] and a 16-bit
//               step counter; takes commands from LA lines and Wishbone,
//               arbitrated round-robin, and sequences the counter datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module la_checkbit_sequencer
    import la_seq_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter logic [31:0] STAT_ADDR = 32'h3000_0004
) (
    input  logic        clock,
    input  logic        resetb,
    input  logic [63:0] la_data_in,
    input  logic [63:0] la_oenb,
    output logic [63:0] la_data_out,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [15:0] io_out,
    output logic [15:0] io_oeb
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_chk;
    logic [15:0] r_cnt;
    logic [15:0] r_rem;
    logic        r_oe_en;
    logic        r_la_pend;
    logic        r_wb_pend;
    logic        r_wb_held;
    logic        r_overrun;
    logic        r_la_tog_q;
    cmd_t        r_la_cmd;
    cmd_t        r_wb_cmd;
    cmd_t        r_cmd;
    logic        r_cmd_wb;

    logic        w_la_edge;
    logic        w_wb_req;
    logic        w_wb_cmd_wr;
    logic        w_gnt_la;
    logic        w_gnt_wb;
    logic        w_last_grant;
    logic        w_busy;
    logic [31:0] w_rd_data;
    logic        w_unused;

    assign w_unused    = ^{la_data_in[63:19], la_oenb[63:19], wbs_dat_i[31:18]};
    assign w_la_edge   = (la_data_in[18] != r_la_tog_q) && (la_oenb[18:0] == 19'd0);
    assign w_wb_req    = wbs_cyc_i && wbs_stb_i;
    assign w_wb_cmd_wr = w_wb_req && wbs_we_i && (wbs_adr_i == BASE_ADDR);
    assign w_busy      = (r_state != ST_IDLE);

    la_seq_rr_arb u_arb (
        .i_clk        (clock),
        .i_rst_n      (resetb),
        .i_en         (r_state == ST_IDLE),
        .i_req_la     (r_la_pend),
        .i_req_wb     (r_wb_pend),
        .o_gnt_la     (w_gnt_la),
        .o_gnt_wb     (w_gnt_wb),
        .o_last_grant (w_last_grant)
    );

    // State register
    always_ff @(posedge clock) begin
        if (!resetb) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: IDLE waits for a grant, EXEC is one cycle, RUN drains REM
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_gnt_la || w_gnt_wb) w_state_nxt = ST_EXEC;
            ST_EXEC: w_state_nxt = (r_cmd.op == OP_RUN) ? ST_RUN : ST_DONE;
            ST_RUN:  if (r_rem == 16'd0) w_state_nxt = ST_DONE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Status read mux for Wishbone reads
    always_comb begin
        w_rd_data = 32'd0;
        if (wbs_adr_i == BASE_ADDR) begin
            w_rd_data = {26'd0, r_overrun, w_last_grant, r_state, w_busy, r_oe_en};
        end else if (wbs_adr_i == STAT_ADDR) begin
            w_rd_data = {r_cnt, r_chk};
        end
    end

    // Request capture, command latch, datapath and Wishbone handshake
    always_ff @(posedge clock) begin
        if (!resetb) begin
            r_chk      <= 16'd0;
            r_cnt      <= 16'd0;
            r_rem      <= 16'd0;
            r_oe_en    <= 1'b0;
            r_la_pend  <= 1'b0;
            r_wb_pend  <= 1'b0;
            r_wb_held  <= 1'b0;
            r_overrun  <= 1'b0;
            r_la_tog_q <= la_data_in[18];
            r_la_cmd   <= '0;
            r_wb_cmd   <= '0;
            r_cmd      <= '0;
            r_cmd_wb   <= 1'b0;
            wbs_ack_o  <= 1'b0;
            wbs_dat_o  <= 32'd0;
        end else begin
            r_la_tog_q <= la_data_in[18];

            // A grant consumes the pending flag; an edge on a full slot is an overrun
            if (w_gnt_la) r_la_pend <= 1'b0;
            if (w_la_edge) begin
                if (r_la_pend) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_la_pend <= 1'b1;
                    r_la_cmd  <= la_data_in[17:0];
                end
            end

            // A command write is captured once per transfer; held stalls re-capture
            if (w_gnt_wb) r_wb_pend <= 1'b0;
            if (w_wb_cmd_wr && !r_wb_held && !wbs_ack_o) begin
                r_wb_pend <= 1'b1;
                r_wb_cmd  <= wbs_dat_i[17:0];
                r_wb_held <= 1'b1;
            end else if (!w_wb_req || wbs_ack_o) begin
                r_wb_held <= 1'b0;
            end

            if (w_gnt_la) begin
                r_cmd    <= r_la_cmd;
                r_cmd_wb <= 1'b0;
            end else if (w_gnt_wb) begin
                r_cmd    <= r_wb_cmd;
                r_cmd_wb <= 1'b1;
            end

            case (r_state)
                ST_EXEC: begin
                    case (r_cmd.op)
                        OP_WCHK: begin
                            r_chk   <= r_cmd.data;
                            r_oe_en <= 1'b1;
                        end
                        OP_LOAD: r_cnt <= r_cmd.data;
                        OP_RUN:  r_rem <= r_cmd.data;
                        OP_NOP:  ;
                        default: ;
                    endcase
                end
                ST_RUN: begin
                    if (r_rem == 16'd0) begin
                        r_chk <= r_cnt;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                        r_rem <= r_rem - 16'd1;
                    end
                end
                default: ;
            endcase

            // Reads and non-command writes ack next cycle; command writes ack after EXEC
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= 32'd0;
            if (w_wb_req && !w_wb_cmd_wr && !wbs_ack_o) begin
                wbs_ack_o <= 1'b1;
                if (!wbs_we_i) wbs_dat_o <= w_rd_data;
            end else if (r_state == ST_EXEC && r_cmd_wb) begin
                wbs_ack_o <= 1'b1;
            end
        end
    end

    // Status view for the LA
    always_comb begin
        la_data_out = 64'd0;
        la_data_out[LDO_CHK_LSB +: 16]  = r_chk;
        la_data_out[LDO_CNT_LSB +: 16]  = r_cnt;
        la_data_out[LDO_BUSY]           = w_busy;
        la_data_out[LDO_STATE_LSB +: 2] = r_state;
        la_data_out[LDO_LAST_GNT]       = w_last_grant;
        la_data_out[LDO_OVERRUN]        = r_overrun;
    end

    assign io_out = r_chk;
    assign io_oeb = {16{~r_oe_en}};

endmodule
`default_nettype wire

// File: tb/tb_la_checkbit_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_la_checkbit_sequencer
// Description : Directed self-checking bench for la_checkbit_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_la_checkbit_sequencer;

    localparam logic [31:0] C_BASE  = 32'h3000_0000;
    localparam logic [31:0] C_STAT  = 32'h3000_0004;
    localparam logic [31:0] C_OTHER = 32'h3000_0008;

    logic        clock = 1'b0;
    logic        resetb;
    logic [63:0] la_data_in;
    logic [63:0] la_oenb;
    logic [63:0] la_data_out;
    logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [31:0] wbs_adr_i, wbs_dat_i, wbs_dat_o;
    logic        wbs_ack_o;
    logic [15:0] io_out, io_oeb;

    int checks   = 0;
    int failures = 0;
    int busy_cnt;

    la_checkbit_sequencer dut (
        .clock       (clock),
        .resetb      (resetb),
        .la_data_in  (la_data_in),
        .la_oenb     (la_oenb),
        .la_data_out (la_data_out),
        .wbs_cyc_i   (wbs_cyc_i),
        .wbs_stb_i   (wbs_stb_i),
        .wbs_we_i    (wbs_we_i),
        .wbs_adr_i   (wbs_adr_i),
        .wbs_dat_i   (wbs_dat_i),
        .wbs_ack_o   (wbs_ack_o),
        .wbs_dat_o   (wbs_dat_o),
        .io_out      (io_out),
        .io_oeb      (io_oeb)
    );

    always #5 clock = ~clock;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue an LA command by flipping the toggle bit
    task automatic la_cmd(input logic [1:0] op, input logic [15:0] data);
        la_data_in[17:0] = {op, data};
        la_data_in[18]   = ~la_data_in[18];
    endtask

    task automatic wb_start(input logic we, input logic [31:0] adr, input logic [31:0] dat);
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = we;
        wbs_adr_i = adr;
        wbs_dat_i = dat;
    endtask

    task automatic wb_stop();
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
    endtask

    initial begin
        resetb     = 1'b0;
        la_data_in = 64'hFFFF_0000_0000_0000;
        la_oenb    = 64'hFFFF_FFFF_FFF8_0000;
        wbs_cyc_i  = 1'b0;
        wbs_stb_i  = 1'b0;
        wbs_we_i   = 1'b0;
        wbs_adr_i  = 32'd0;
        wbs_dat_i  = 32'd0;
        tick(2);
        resetb = 1'b1;
        tick(1);

        // Reset state
        chk("rst_la_out", la_data_out, 64'd0);
        chk("rst_io_out", {48'd0, io_out}, 64'd0);
        chk("rst_io_oeb", {48'd0, io_oeb}, 64'h0000_FFFF);
        chk("rst_ack", {63'd0, wbs_ack_o}, 64'd0);

        // LA WRITE_CHK 0xAB40: visible three edges after the toggle
        la_cmd(2'd1, 16'hAB40);
        tick(2);
        chk("wchk_latency", {48'd0, io_out}, 64'd0);
        chk("wchk_exec_status", {59'd0, la_data_out[36:32]}, 64'h0B);
        tick(1);
        chk("wchk_io_out", {48'd0, io_out}, 64'hAB40);
        chk("wchk_io_oeb", {48'd0, io_oeb}, 64'd0);
        chk("wchk_la_chk", {48'd0, la_data_out[15:0]}, 64'hAB40);
        tick(1);

        // LOAD_CNT 0xAB41, WRITE_CHK 0xAB41, RUN 16
        la_cmd(2'd2, 16'hAB41);
        tick(4);
        chk("load_cnt", {48'd0, la_data_out[31:16]}, 64'hAB41);
        chk("load_io_unchanged", {48'd0, io_out}, 64'hAB40);
        la_cmd(2'd1, 16'hAB41);
        tick(4);
        chk("wchk2_io_out", {48'd0, io_out}, 64'hAB41);
        la_cmd(2'd3, 16'd16);
        busy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (la_data_out[32]) busy_cnt++;
        end
        chk("run16_busy_cycles", 64'(busy_cnt), 64'd19);
        chk("run16_io_out", {48'd0, io_out}, 64'hAB51);
        chk("run16_cnt", {48'd0, la_data_out[31:16]}, 64'hAB51);

        // LA edge masked by la_oenb is ignored
        la_oenb[5] = 1'b1;
        la_cmd(2'd1, 16'h1111);
        tick(5);
        chk("oenb_masked", {48'd0, io_out}, 64'hAB51);
        chk("oenb_idle", {63'd0, la_data_out[32]}, 64'd0);
        la_oenb[5] = 1'b0;
        tick(2);

        // Simultaneous LA and WB requests after reset: LA first, then WB
        resetb = 1'b0;
        tick(1);
        resetb = 1'b1;
        la_cmd(2'd1, 16'h1234);
        wb_start(1'b1, C_BASE, {14'd0, 2'd2, 16'h5678});
        tick(2);
        chk("arb_la_first", {59'd0, la_data_out[36:32]}, 64'h0B);
        chk("arb_no_ack_early", {63'd0, wbs_ack_o}, 64'd0);
        tick(1);
        chk("arb_la_chk", {48'd0, io_out}, 64'h1234);
        tick(2);
        chk("arb_wb_second", {59'd0, la_data_out[36:32]}, 64'h03);
        chk("arb_wb_stall", {63'd0, wbs_ack_o}, 64'd0);
        tick(1);
        chk("arb_wb_ack", {63'd0, wbs_ack_o}, 64'd1);
        chk("arb_wb_cnt", {48'd0, la_data_out[31:16]}, 64'h5678);
        wb_stop();
        tick(1);
        chk("arb_ack_pulse", {63'd0, wbs_ack_o}, 64'd0);
        tick(3);
        chk("arb_no_repeat", {48'd0, la_data_out[47:32]}, 64'd0);

        // Wishbone reads
        wb_start(1'b0, C_STAT, 32'd0);
        tick(1);
        chk("rd_stat_ack", {63'd0, wbs_ack_o}, 64'd1);
        chk("rd_stat_dat", {32'd0, wbs_dat_o}, 64'h5678_1234);
        wb_stop();
        tick(1);
        wb_start(1'b0, C_BASE, 32'd0);
        tick(1);
        chk("rd_base_dat", {32'd0, wbs_dat_o}, 64'h01);
        wb_stop();
        tick(1);
        wb_start(1'b0, C_OTHER, 32'd0);
        tick(1);
        chk("rd_other_ack", {63'd0, wbs_ack_o}, 64'd1);
        chk("rd_other_dat", {32'd0, wbs_dat_o}, 64'd0);
        wb_stop();
        tick(1);

        // Overrun: two LA toggles during RUN 100; first runs later, second dropped
        la_cmd(2'd3, 16'd100);
        tick(5);
        la_cmd(2'd1, 16'hBEEF);
        tick(3);
        la_cmd(2'd1, 16'hDEAD);
        tick(2);
        chk("ovr_flag_early", {63'd0, la_data_out[36]}, 64'd1);
        tick(130);
        chk("ovr_io_out", {48'd0, io_out}, 64'hBEEF);
        chk("ovr_cnt", {48'd0, la_data_out[31:16]}, 64'h56DC);
        chk("ovr_status", {59'd0, la_data_out[36:32]}, 64'h18);
        wb_start(1'b0, C_BASE, 32'd0);
        tick(1);
        chk("ovr_rd_base", {32'd0, wbs_dat_o}, 64'h31);
        wb_stop();
        tick(1);

        // Reset in the middle of RUN 50
        la_cmd(2'd3, 16'd50);
        tick(10);
        chk("mid_run_busy", {61'd0, la_data_out[34:32]}, 64'h5);
        resetb = 1'b0;
        tick(1);
        resetb = 1'b1;
        chk("rst_run_la_out", la_data_out, 64'd0);
        chk("rst_run_io_oeb", {48'd0, io_oeb}, 64'h0000_FFFF);
        tick(3);
        chk("rst_run_no_ack", {63'd0, wbs_ack_o}, 64'd0);
        chk("rst_run_stays_idle", la_data_out, 64'd0);

        // Counter wrap: RUN 0 with CNT=0xFFFF, then RUN 1
        la_cmd(2'd2, 16'hFFFF);
        tick(4);
        la_cmd(2'd3, 16'd0);
        tick(5);
        chk("run0_chk", {48'd0, io_out}, 64'hFFFF);
        chk("run0_oeb", {48'd0, io_oeb}, 64'hFFFF);
        la_cmd(2'd3, 16'd1);
        tick(6);
        chk("run1_wrap_cnt", {48'd0, la_data_out[31:16]}, 64'd0);
        chk("run1_wrap_chk", {48'd0, io_out}, 64'd0);
        chk("run1_idle", {63'd0, la_data_out[32]}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
